timer_irq: RTL and testbench
============================

TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 Parameter: WIDTH, 16, width of reload, count and data buses.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: tick  input  1  one-cycle terminal-count pulse from the upstream prescaler counter.
REQ-005 Port: wr_en  input  1  register write strobe, one cycle per write.
REQ-006 Port: addr  input  2  register select: 0 = RELOAD, 1 = CTRL, 2 = COUNT (read-only), 3 = reserved.
REQ-007 Port: wr_data  input  WIDTH  write data.
REQ-008 Port: rd_data  output  WIDTH  combinational read of the register selected by addr.
REQ-009 Port: irq  output  1  registered interrupt request, level, held until acknowledged.
REQ-010 Port: irq_ack  input  1  one-cycle acknowledge; clears the done flag and irq.

Function
REQ-011 CTRL bits SHALL be: [0] en, [1] auto (auto-reload), [2] ie (interrupt enable), [3] done (read-only; writes ignored); bits [WIDTH-1:4] read 0.
REQ-012 FSM states SHALL be IDLE, RUN, EXPIRED; en reads 1 only in RUN.
REQ-013 IDLE/EXPIRED -> RUN on a CTRL write with wr_data[0]=1 and RELOAD != 0; count <= RELOAD in the same edge.
REQ-014 A CTRL write with wr_data[0]=1 and RELOAD = 0 SHALL be ignored for en (state unchanged); auto/ie still update.
REQ-015 RUN: each tick SHALL decrement count by 1; no change on cycles without tick.
REQ-016 RUN, tick with count = 1: done <= 1; if auto=1, count <= RELOAD and stay RUN; if auto=0, count <= 0 and -> EXPIRED.
REQ-017 Expiry latency: done and irq SHALL be visible the cycle after the expiring tick edge; irq = done AND ie (registered).
REQ-018 A CTRL write with wr_data[0]=0 SHALL -> IDLE from any state; count holds its value; done unchanged.
REQ-019 Writing RELOAD while RUN SHALL not alter count; new value takes effect at next start or auto-reload.
REQ-020 CTRL write and tick in the same cycle: the write SHALL take priority; the tick is discarded.
REQ-021 irq_ack and a new expiry in the same cycle: done SHALL remain 1 (set wins).
REQ-022 irq_ack with done = 0 SHALL have no effect.
REQ-023 Clearing ie SHALL deassert irq next cycle while done stays 1; setting ie with done = 1 SHALL assert irq next cycle.
REQ-024 count SHALL never wrap below 0; ticks in IDLE/EXPIRED are ignored.
REQ-025 Writes to addr 2 or 3 SHALL be ignored; reads of addr 3 return 0.

Reset
REQ-026 reset = 0 SHALL immediately force: state IDLE, RELOAD = 0, count = 0, en/auto/ie/done = 0, irq = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the countdown; no done/irq is produced for the aborted period.
REQ-028 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-029 One-shot: RELOAD=3, CTRL=0x5, 3 ticks -> done=1, irq=1 one cycle after 3rd tick; state EXPIRED, COUNT=0; irq_ack -> irq=0 next cycle.
REQ-030 Auto-reload: RELOAD=2, CTRL=0x7, 6 ticks -> irq set after tick 2, COUNT reads 2,1,2,1,2; remains RUN throughout.
REQ-031 Zero reload: RELOAD=0, CTRL=0x1 -> CTRL reads 0x0, state IDLE; ticks leave COUNT=0 and irq=0.
REQ-032 Collisions: CTRL=0x0 write coincident with tick at COUNT=1 -> IDLE, COUNT=1, done=0; irq_ack coincident with auto-reload expiry -> done stays 1.
REQ-033 Reset mid-run: RELOAD=5, run 2 ticks, pulse reset low -> all registers 0, irq=0, no irq after further ticks.
REQ-034 Mask: ie=0 expiry -> done=1, irq=0; then CTRL=0x4 -> irq=1 next cycle.

Source files
------------

// File: rtl/timer_irq.sv
// Reloadable down-counter timer driven by prescaler ticks, with a small
// register file (RELOAD/CTRL/COUNT) and a level interrupt held until acknowledged.
module timer_irq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             wr_en,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             irq,
   input  logic             irq_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_C = '0;
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

   state_t           state_r, state_nxt_s;
   logic [WIDTH-1:0] reload_r, reload_nxt_s;
   logic [WIDTH-1:0] count_r, count_nxt_s;
   logic             auto_r, auto_nxt_s;
   logic             ie_r, ie_nxt_s;
   logic             done_r, done_nxt_s;
   logic             irq_r, irq_nxt_s;
   logic             ctrl_wr_s, reload_wr_s, expire_s;

   assign ctrl_wr_s   = wr_en && (addr == 2'd1);
   assign reload_wr_s = wr_en && (addr == 2'd0);

   // Next-state logic: a CTRL write always outranks a same-cycle tick.
   always_comb begin
      state_nxt_s  = state_r;
      reload_nxt_s = reload_r;
      count_nxt_s  = count_r;
      auto_nxt_s   = auto_r;
      ie_nxt_s     = ie_r;
      expire_s     = 1'b0;

      if (reload_wr_s) begin
         reload_nxt_s = wr_data;
      end else begin
         reload_nxt_s = reload_r;
      end

      if (ctrl_wr_s) begin
         auto_nxt_s = wr_data[1];
         ie_nxt_s   = wr_data[2];
         if (!wr_data[0]) begin
            state_nxt_s = IDLE;
         end else if ((state_r != RUN) && (reload_r != ZERO_C)) begin
            state_nxt_s = RUN;
            count_nxt_s = reload_r;
         end else begin
            state_nxt_s = state_r;
         end
      end else if ((state_r == RUN) && tick) begin
         if (count_r == ONE_C) begin
            expire_s = 1'b1;
            // A zero RELOAD at auto-reload time would leave RUN with count 0, so stop instead.
            if (auto_r && (reload_r != ZERO_C)) begin
               count_nxt_s = reload_r;
            end else begin
               count_nxt_s = ZERO_C;
               state_nxt_s = EXPIRED;
            end
         end else if (count_r != ZERO_C) begin
            count_nxt_s = count_r - ONE_C;
         end else begin
            count_nxt_s = count_r;
         end
      end else begin
         count_nxt_s = count_r;
      end

      if (expire_s) begin
         done_nxt_s = 1'b1;
      end else if (irq_ack) begin
         done_nxt_s = 1'b0;
      end else begin
         done_nxt_s = done_r;
      end

      irq_nxt_s = done_nxt_s & ie_nxt_s;
   end

   // State and register update with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         reload_r <= ZERO_C;
         count_r  <= ZERO_C;
         auto_r   <= 1'b0;
         ie_r     <= 1'b0;
         done_r   <= 1'b0;
         irq_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         reload_r <= reload_nxt_s;
         count_r  <= count_nxt_s;
         auto_r   <= auto_nxt_s;
         ie_r     <= ie_nxt_s;
         done_r   <= done_nxt_s;
         irq_r    <= irq_nxt_s;
      end
   end

   // Register read mux.
   always_comb begin
      rd_data = ZERO_C;
      case (addr)
         2'd0:    rd_data = reload_r;
         2'd1:    rd_data = {{(WIDTH-4){1'b0}}, done_r, ie_r, auto_r, (state_r == RUN)};
         2'd2:    rd_data = count_r;
         default: rd_data = ZERO_C;
      endcase
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_timer_irq.sv
// Directed, table-driven bench for timer_irq with hand-computed expectations,
// plus a hand-written reset-mid-run sequence.
module tb_timer_irq;

   localparam int WIDTH = 16;

   logic             clk;
   logic             reset;
   logic             tick;
   logic             wr_en;
   logic [1:0]       addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic             irq;
   logic             irq_ack;

   int checks_r;
   int errors_r;

   typedef struct {
      logic             we;
      logic [1:0]       a;
      logic [WIDTH-1:0] d;
      logic             tk;
      logic             ack;
      logic [1:0]       ca;
      logic [WIDTH-1:0] exp_rd;
      logic             exp_irq;
      string            name;
   } vec_t;

   vec_t vecs[$];

   timer_irq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr_en   (wr_en),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .irq     (irq),
      .irq_ack (irq_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks_r = checks_r + 1;
      if (act !== exp) begin
         errors_r = errors_r + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [1:0] a, input logic [WIDTH-1:0] d,
                      input logic tk, input logic ack, input logic [1:0] ca,
                      input logic [WIDTH-1:0] exp_rd, input logic exp_irq, input string name);
      vec_t v;
      v.we = we; v.a = a; v.d = d; v.tk = tk; v.ack = ack;
      v.ca = ca; v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.name = name;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, then read back the selected register after the edge.
   task automatic cyc(input logic we, input logic [1:0] a, input logic [WIDTH-1:0] d,
                      input logic tk, input logic ack, input logic [1:0] ca);
      @(negedge clk);
      wr_en = we; addr = a; wr_data = d; tick = tk; irq_ack = ack;
      @(posedge clk);
      #1;
      wr_en = 1'b0; tick = 1'b0; irq_ack = 1'b0; addr = ca;
      #1;
   endtask

   initial begin
      checks_r = 0;
      errors_r = 0;
      reset = 1'b0; tick = 1'b0; wr_en = 1'b0; addr = 2'd0;
      wr_data = '0; irq_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_reload", rd_data, 16'h0000);
      addr = 2'd1; #1; chk("rst_ctrl", rd_data, 16'h0000);
      addr = 2'd2; #1; chk("rst_count", rd_data, 16'h0000);
      chk("rst_irq", {15'd0, irq}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // one-shot
      add(1'b1, 2'd0, 16'd3,     1'b0, 1'b0, 2'd0, 16'd3,     1'b0, "os_wr_reload");
      add(1'b1, 2'd1, 16'h0005,  1'b0, 1'b0, 2'd2, 16'd3,     1'b0, "os_start");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd2,     1'b0, "os_tick1");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b0, 2'd2, 16'd2,     1'b0, "os_notick");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b0, "os_tick2");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd1, 16'h000C,  1'b1, "os_expire");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd0,     1'b1, "os_tick_expired");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b1, 2'd1, 16'h0004,  1'b0, "os_ack");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b1, 2'd1, 16'h0004,  1'b0, "ack_no_done");
      // auto-reload with coincident ack
      add(1'b1, 2'd0, 16'd2,     1'b0, 1'b0, 2'd0, 16'd2,     1'b0, "ar_wr_reload");
      add(1'b1, 2'd1, 16'h0007,  1'b0, 1'b0, 2'd1, 16'h0007,  1'b0, "ar_start");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b0, "ar_tick1");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd2,     1'b1, "ar_tick2");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b1, "ar_tick3");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b1, 2'd1, 16'h000F,  1'b1, "ar_ack_vs_expiry");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b1, 2'd1, 16'h0007,  1'b0, "ar_ack");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b0, "ar_tick5");
      // stop coincident with tick
      add(1'b1, 2'd1, 16'h0000,  1'b1, 1'b0, 2'd1, 16'h0000,  1'b0, "col_stop_ctrl");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b0, 2'd2, 16'd1,     1'b0, "col_stop_count");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b0, "idle_tick");
      // reload write while running, masked expiry, ie toggling
      add(1'b1, 2'd1, 16'h0001,  1'b0, 1'b0, 2'd2, 16'd2,     1'b0, "m_start");
      add(1'b1, 2'd0, 16'd9,     1'b0, 1'b0, 2'd2, 16'd2,     1'b0, "m_reload_in_run");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd1,     1'b0, "m_tick1");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd1, 16'h0008,  1'b0, "m_masked_expiry");
      add(1'b1, 2'd1, 16'h0004,  1'b0, 1'b0, 2'd1, 16'h000C,  1'b1, "m_set_ie");
      add(1'b1, 2'd1, 16'h0000,  1'b0, 1'b0, 2'd1, 16'h0008,  1'b0, "m_clr_ie");
      add(1'b1, 2'd1, 16'h0001,  1'b0, 1'b0, 2'd2, 16'd9,     1'b0, "m_restart_new_reload");
      add(1'b0, 2'd0, 16'd0,     1'b0, 1'b1, 2'd1, 16'h0001,  1'b0, "m_ack");
      // zero reload, read-only/reserved addresses
      add(1'b1, 2'd1, 16'h0000,  1'b0, 1'b0, 2'd1, 16'h0000,  1'b0, "z_stop");
      add(1'b1, 2'd0, 16'd0,     1'b0, 1'b0, 2'd0, 16'd0,     1'b0, "z_wr_reload0");
      add(1'b1, 2'd1, 16'h0001,  1'b0, 1'b0, 2'd1, 16'h0000,  1'b0, "z_start_ignored");
      add(1'b1, 2'd1, 16'h0007,  1'b0, 1'b0, 2'd1, 16'h0006,  1'b0, "z_auto_ie_update");
      add(1'b0, 2'd0, 16'd0,     1'b1, 1'b0, 2'd2, 16'd9,     1'b0, "z_tick_ignored");
      add(1'b1, 2'd2, 16'h0055,  1'b0, 1'b0, 2'd2, 16'd9,     1'b0, "wr_count_ignored");
      add(1'b1, 2'd3, 16'hFFFF,  1'b0, 1'b0, 2'd3, 16'h0000,  1'b0, "rd_reserved");
      add(1'b1, 2'd1, 16'hFFF8,  1'b0, 1'b0, 2'd1, 16'h0000,  1'b0, "ctrl_upper_zero");

      foreach (vecs[i]) begin
         cyc(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].tk, vecs[i].ack, vecs[i].ca);
         chk({vecs[i].name, "_rd"}, rd_data, vecs[i].exp_rd);
         chk({vecs[i].name, "_irq"}, {15'd0, irq}, {15'd0, vecs[i].exp_irq});
      end

      // reset asserted mid-run aborts the countdown
      cyc(1'b1, 2'd0, 16'd5,    1'b0, 1'b0, 2'd2);
      cyc(1'b1, 2'd1, 16'h0005, 1'b0, 1'b0, 2'd2);
      chk("rr_start", rd_data, 16'd5);
      cyc(1'b0, 2'd0, 16'd0,    1'b1, 1'b0, 2'd2);
      cyc(1'b0, 2'd0, 16'd0,    1'b1, 1'b0, 2'd2);
      chk("rr_two_ticks", rd_data, 16'd3);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("rr_async_count", rd_data, 16'd0);
      addr = 2'd0; #1; chk("rr_async_reload", rd_data, 16'd0);
      addr = 2'd1; #1; chk("rr_async_ctrl", rd_data, 16'd0);
      chk("rr_async_irq", {15'd0, irq}, 16'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 2'd1);
      end
      chk("rr_no_expiry_ctrl", rd_data, 16'd0);
      chk("rr_no_irq", {15'd0, irq}, 16'd0);
      addr = 2'd2; #1; chk("rr_count_after", rd_data, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
